// File: rtl/hex_seq_pkg.sv
// Shared types, glyph/value tables and sequence helpers for the hex sequence monitor.
// Pattern bit order is {seg1..seg7}: top, top-right, bottom-right, bottom, bottom-left, top-left, middle.
package hex_seq_pkg;

    typedef logic [3:0] pos_t;

    typedef enum logic [1:0] {
        BUSCA    = 2'd0,
        UM_VISTO = 2'd1,
        TRAVADO  = 2'd2
    } estado_e;

    // Sequence order 2,5,7,3,A,E,8,0,b,4,6,d,F,1,C,9.
    localparam logic [6:0] GLYPH_TAB [16] = '{
        7'b1101101, 7'b1011011, 7'b1110000, 7'b1111001,
        7'b1110111, 7'b1001111, 7'b1111111, 7'b1111110,
        7'b0011111, 7'b0110011, 7'b1011111, 7'b0111101,
        7'b1000111, 7'b0110000, 7'b1001110, 7'b1110011
    };

    localparam logic [3:0] HEX_TAB [16] = '{
        4'h2, 4'h5, 4'h7, 4'h3, 4'hA, 4'hE, 4'h8, 4'h0,
        4'hB, 4'h4, 4'h6, 4'hD, 4'hF, 4'h1, 4'hC, 4'h9
    };

    // 4-bit arithmetic gives the 15->0 and 0->15 wrap for free.
    function automatic pos_t succ_pos(input pos_t p);
        return p + 4'd1;
    endfunction

    function automatic pos_t pred_pos(input pos_t p);
        return p - 4'd1;
    endfunction

endpackage

// File: rtl/seg_decod.sv
// Combinational seven-segment decoder: pattern to {legal, sequence position}.
module seg_decod
    import hex_seq_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output pos_t       pos_o
);

    // Table lookup; patterns are unique so at most one entry matches.
    always_comb begin
        legal_o = 1'b0;
        pos_o   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            legal_o = legal_o | (seg_i == GLYPH_TAB[i]);
            pos_o   = (seg_i == GLYPH_TAB[i]) ? 4'(i) : pos_o;
        end
    end

endmodule

// File: rtl/monitor_hex.sv
// Seven-segment sequence monitor: locks onto the glyph sequence forwards or backwards.
// Define MONITOR_HEX_ERR_COUNT_EN to build the saturating error counter.
module monitor_hex
    import hex_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       seg1,
    input  logic       seg2,
    input  logic       seg3,
    input  logic       seg4,
    input  logic       seg5,
    input  logic       seg6,
    input  logic       seg7,
    input  logic       amostra,
    output logic [3:0] valor,
    output logic       valido,
    output logic       travado,
    output logic       direcao,
    output logic       erro,
    output logic [7:0] contagem_erros
);

    logic [6:0] seg_s;
    logic       legal_s;
    pos_t       pos_s;

    estado_e    estado_d, estado_q;
    pos_t       pos_d, pos_q;
    logic [3:0] valor_d, valor_q;
    logic       valido_d, valido_q;
    logic       travado_d, travado_q;
    logic       direcao_d, direcao_q;
    logic       erro_d, erro_q;

    assign seg_s = {seg1, seg2, seg3, seg4, seg5, seg6, seg7};

    seg_decod u_seg_decod (
        .seg_i   (seg_s),
        .legal_o (legal_s),
        .pos_o   (pos_s)
    );

    // Next-state logic; nothing moves and erro stays low unless amostra is high.
    always_comb begin
        estado_d  = estado_q;
        pos_d     = pos_q;
        valor_d   = valor_q;
        valido_d  = valido_q;
        direcao_d = direcao_q;
        erro_d    = 1'b0;
        if (amostra) begin
            valido_d = legal_s;
            if (legal_s) begin
                valor_d = HEX_TAB[pos_s];
            end else begin
                valor_d = valor_q;
            end
            case (estado_q)
                BUSCA: begin
                    if (legal_s) begin
                        estado_d = UM_VISTO;
                        pos_d    = pos_s;
                    end else begin
                        estado_d = BUSCA;
                    end
                end
                UM_VISTO: begin
                    if (!legal_s) begin
                        estado_d = BUSCA;
                    end else if (pos_s == succ_pos(pos_q)) begin
                        estado_d  = TRAVADO;
                        direcao_d = 1'b0;
                        pos_d     = pos_s;
                    end else if (pos_s == pred_pos(pos_q)) begin
                        estado_d  = TRAVADO;
                        direcao_d = 1'b1;
                        pos_d     = pos_s;
                    end else begin
                        estado_d = UM_VISTO;
                        pos_d    = pos_s;
                    end
                end
                TRAVADO: begin
                    if (!legal_s) begin
                        estado_d = BUSCA;
                        erro_d   = 1'b1;
                    end else if (pos_s == pos_q) begin
                        estado_d = TRAVADO;
                    end else if (pos_s == (direcao_q ? pred_pos(pos_q) : succ_pos(pos_q))) begin
                        estado_d = TRAVADO;
                        pos_d    = pos_s;
                    end else if (pos_s == (direcao_q ? succ_pos(pos_q) : pred_pos(pos_q))) begin
                        estado_d  = TRAVADO;
                        direcao_d = ~direcao_q;
                        pos_d     = pos_s;
                    end else begin
                        estado_d = UM_VISTO;
                        pos_d    = pos_s;
                        erro_d   = 1'b1;
                    end
                end
                default: begin
                    estado_d = BUSCA;
                end
            endcase
        end else begin
            erro_d = 1'b0;
        end
        travado_d = (estado_d == TRAVADO);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q  <= BUSCA;
            pos_q     <= 4'd0;
            valor_q   <= 4'd0;
            valido_q  <= 1'b0;
            travado_q <= 1'b0;
            direcao_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            pos_q     <= pos_d;
            valor_q   <= valor_d;
            valido_q  <= valido_d;
            travado_q <= travado_d;
            direcao_q <= direcao_d;
            erro_q    <= erro_d;
        end
    end

    assign valor   = valor_q;
    assign valido  = valido_q;
    assign travado = travado_q;
    assign direcao = direcao_q;
    assign erro    = erro_q;

`ifdef MONITOR_HEX_ERR_COUNT_EN
    logic [7:0] cnt_d, cnt_q;

    // Counts in step with the erro register so both show the same event together.
    always_comb begin
        if (erro_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign contagem_erros = cnt_q;
`else
    assign contagem_erros = 8'd0;
`endif

endmodule

// File: tb/tb_monitor_hex.sv
// Directed self-checking bench for monitor_hex; expectations follow the build's
// MONITOR_HEX_ERR_COUNT_EN setting for the error counter.
module tb_monitor_hex;

`ifdef MONITOR_HEX_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G9 = 7'b1110011;

    logic [6:0] gl [16] = '{
        7'b1101101, 7'b1011011, 7'b1110000, 7'b1111001,
        7'b1110111, 7'b1001111, 7'b1111111, 7'b1111110,
        7'b0011111, 7'b0110011, 7'b1011111, 7'b0111101,
        7'b1000111, 7'b0110000, 7'b1001110, 7'b1110011
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       seg1 = 1'b0, seg2 = 1'b0, seg3 = 1'b0, seg4 = 1'b0;
    logic       seg5 = 1'b0, seg6 = 1'b0, seg7 = 1'b0;
    logic       amostra = 1'b0;
    logic [3:0] valor;
    logic       valido, travado, direcao, erro;
    logic [7:0] contagem_erros;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    monitor_hex dut (
        .clk(clk), .reset(reset),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .seg5(seg5), .seg6(seg6), .seg7(seg7),
        .amostra(amostra),
        .valor(valor), .valido(valido), .travado(travado),
        .direcao(direcao), .erro(erro), .contagem_erros(contagem_erros)
    );

    always #5 clk = ~clk;

    // {valor, valido, travado, direcao, erro}
    function automatic logic [7:0] outs();
        return {valor, valido, travado, direcao, erro};
    endfunction

    task automatic do_sample(input logic [6:0] p);
        {seg1, seg2, seg3, seg4, seg5, seg6, seg7} = p;
        amostra = 1'b1;
        @(posedge clk);
        #1;
        amostra = 1'b0;
    endtask

    task automatic apply_reset();
        amostra = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        chk_cnt++;
        if ({outs(), contagem_erros} !== 16'h0000) $display("FAIL reset_init got %h exp 0000", {outs(), contagem_erros});
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b1;
        do_sample(G2);
        do_sample(G5);
        do_sample(GA);
        do_sample(G0);  // break from UM_VISTO-free path: GA->G0 in UM_VISTO, no error
        do_sample(G8);  // 8 is predecessor of 0: locked backward
        chk_cnt++;
        if (outs() !== {4'h8, 1'b1, 1'b1, 1'b1, 1'b0}) $display("FAIL reset_prelock got %b exp %b", outs(), {4'h8, 4'b1110});
        else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        chk_cnt++;
        if ({outs(), contagem_erros} !== 16'h0000) $display("FAIL reset_midlock got %h exp 0000", {outs(), contagem_erros});
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b1;
        do_sample(G2);
        chk_cnt++;
        if (outs() !== {4'h2, 1'b1, 1'b0, 1'b0, 1'b0}) $display("FAIL reset_first_sample got %b exp %b", outs(), {4'h2, 4'b1000});
        else pass_cnt++;
    endtask

    task automatic test_forward_lock();
        apply_reset();
        do_sample(G2);
        do_sample(G5);
        chk_cnt++;
        if (outs() !== {4'h5, 1'b1, 1'b1, 1'b0, 1'b0}) $display("FAIL fwd_lock5 got %b exp %b", outs(), {4'h5, 4'b1100});
        else pass_cnt++;
        do_sample(G7);
        chk_cnt++;
        if (outs() !== {4'h7, 1'b1, 1'b1, 1'b0, 1'b0}) $display("FAIL fwd_lock7 got %b exp %b", outs(), {4'h7, 4'b1100});
        else pass_cnt++;
        // Idle cycles with an illegal pattern on the pins must change nothing.
        {seg1, seg2, seg3, seg4, seg5, seg6, seg7} = 7'b0000000;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (outs() !== {4'h7, 1'b1, 1'b1, 1'b0, 1'b0}) $display("FAIL fwd_idle_hold got %b exp %b", outs(), {4'h7, 4'b1100});
        else pass_cnt++;
        do_sample(G7);
        chk_cnt++;
        if (outs() !== {4'h7, 1'b1, 1'b1, 1'b0, 1'b0}) $display("FAIL fwd_same got %b exp %b", outs(), {4'h7, 4'b1100});
        else pass_cnt++;
    endtask

    task automatic test_backward_wrap();
        apply_reset();
        do_sample(G5);
        do_sample(G2);
        chk_cnt++;
        if (outs() !== {4'h2, 1'b1, 1'b1, 1'b1, 1'b0}) $display("FAIL bwd_lock2 got %b exp %b", outs(), {4'h2, 4'b1110});
        else pass_cnt++;
        do_sample(G9);
        chk_cnt++;
        if (outs() !== {4'h9, 1'b1, 1'b1, 1'b1, 1'b0}) $display("FAIL bwd_wrap9 got %b exp %b", outs(), {4'h9, 4'b1110});
        else pass_cnt++;
    endtask

    task automatic test_flip_break();
        apply_reset();
        do_sample(G2);
        do_sample(G5);
        do_sample(G7);
        do_sample(G5);
        chk_cnt++;
        if (outs() !== {4'h5, 1'b1, 1'b1, 1'b1, 1'b0}) $display("FAIL flip_dir got %b exp %b", outs(), {4'h5, 4'b1110});
        else pass_cnt++;
        do_sample(G0);
        chk_cnt++;
        if ({outs(), contagem_erros} !== {4'h0, 1'b1, 1'b0, 1'b1, 1'b1, (CNT_EN ? 8'd1 : 8'd0)})
            $display("FAIL break_pulse got %h exp %h", {outs(), contagem_erros}, {4'h0, 4'b1011, (CNT_EN ? 8'd1 : 8'd0)});
        else pass_cnt++;
        @(posedge clk);
        #1;
        chk_cnt++;
        if ({erro, contagem_erros} !== {1'b0, (CNT_EN ? 8'd1 : 8'd0)}) $display("FAIL break_single got %h exp %h", {erro, contagem_erros}, {1'b0, (CNT_EN ? 8'd1 : 8'd0)});
        else pass_cnt++;
        // After the break we sit in UM_VISTO at 0; 8 precedes 0, so relock backward.
        do_sample(G8);
        chk_cnt++;
        if (outs() !== {4'h8, 1'b1, 1'b1, 1'b1, 1'b0}) $display("FAIL break_relock got %b exp %b", outs(), {4'h8, 4'b1110});
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        apply_reset();
        do_sample(7'b0000001);
        chk_cnt++;
        if (outs() !== {4'h0, 1'b0, 1'b0, 1'b0, 1'b0}) $display("FAIL illegal_busca got %b exp %b", outs(), 8'h00);
        else pass_cnt++;
        do_sample(G2);
        do_sample(G5);
        do_sample(7'b0000000);
        chk_cnt++;
        if (outs() !== {4'h5, 1'b0, 1'b0, 1'b0, 1'b1}) $display("FAIL illegal_locked got %b exp %b", outs(), {4'h5, 4'b0001});
        else pass_cnt++;
        // From BUSCA a neighbour of the last position must not lock immediately.
        do_sample(G7);
        chk_cnt++;
        if (outs() !== {4'h7, 1'b1, 1'b0, 1'b0, 1'b0}) $display("FAIL illegal_to_busca got %b exp %b", outs(), {4'h7, 4'b1000});
        else pass_cnt++;
    endtask

    task automatic test_um_visto_other();
        apply_reset();
        do_sample(G2);
        do_sample(GA);
        chk_cnt++;
        if (outs() !== {4'hA, 1'b1, 1'b0, 1'b0, 1'b0}) $display("FAIL uv_other got %b exp %b", outs(), {4'hA, 4'b1000});
        else pass_cnt++;
        do_sample(G3);
        chk_cnt++;
        if (outs() !== {4'h3, 1'b1, 1'b1, 1'b1, 1'b0}) $display("FAIL uv_newpos_lock got %b exp %b", outs(), {4'h3, 4'b1110});
        else pass_cnt++;
        do_sample(7'b0000000);
        do_sample(G3);
        do_sample(7'b1111111 ^ 7'b1111111);
        chk_cnt++;
        if (outs() !== {4'h3, 1'b0, 1'b0, 1'b1, 1'b0}) $display("FAIL uv_illegal got %b exp %b", outs(), {4'h3, 4'b0010});
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int cur;
        int brk;
        int pulses;
        apply_reset();
        do_sample(G2);
        do_sample(G5);
        cur = 1;
        pulses = 0;
        for (int k = 0; k < 260; k++) begin
            brk = (cur + 8) % 16;
            do_sample(gl[brk]);
            if (erro === 1'b1) pulses++;
            cur = (brk + 1) % 16;
            do_sample(gl[cur]);
        end
        chk_cnt++;
        if (pulses !== 260) $display("FAIL sat_pulses got %0d exp 260", pulses);
        else pass_cnt++;
        chk_cnt++;
        if (contagem_erros !== (CNT_EN ? 8'd255 : 8'd0)) $display("FAIL sat_count got %0d exp %0d", contagem_erros, (CNT_EN ? 255 : 0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_forward_lock();
        test_backward_wrap();
        test_flip_break();
        test_illegal();
        test_um_visto_other();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
